// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for every pipeline-boundary buffer instance:
// occupancy state encoding and the bubble control value.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Replicated to CTRL_W by each instance; a bubble never carries control.
    localparam logic BUBBLE_CTRL_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One storage slot (control + data) with load, kill-on-load and clear-to-bubble.
module pipe_stage_entry
    import pipe_stage_buf_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Slot register: clear beats load, a killed load stores a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r <= {CTRL_W{BUBBLE_CTRL_BIT}};
            data_r <= NOP_DATA;
        end else if (clear) begin
            ctrl_r <= {CTRL_W{BUBBLE_CTRL_BIT}};
            data_r <= NOP_DATA;
        end else if (load) begin
            ctrl_r <= kill ? {CTRL_W{BUBBLE_CTRL_BIT}} : d_ctrl;
            data_r <= kill ? NOP_DATA : d_data;
        end else begin
            ctrl_r <= ctrl_r;
            data_r <= data_r;
        end
    end

    assign q_ctrl = ctrl_r;
    assign q_data = data_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-boundary buffer: valid/ready handshake with a 2-entry skid,
// per-entry kill, whole-stage flush and a saturating kill counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kill,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  kill_cnt,
    input  logic              clr_cnt
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              accept_s;
    logic              drain_s;
    logic              head_load_s;
    logic              head_from_skid_s;
    logic              head_clear_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic              head_kill_s;
    logic [CTRL_W-1:0] head_d_ctrl_s;
    logic [DATA_W-1:0] head_d_data_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;
    logic [CNT_W-1:0]  kill_cnt_r;

    // Handshake depends only on registered state and flush, never on out_ready.
    assign in_ready  = ~flush & (state_r != ST_TWO);
    assign out_valid = ~flush & (state_r != ST_EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign drain_s   = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and slot-steering decode; flush overrides every handshake.
    always_comb begin
        state_nxt_s      = state_r;
        head_load_s      = 1'b0;
        head_from_skid_s = 1'b0;
        head_clear_s     = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush) begin
            state_nxt_s  = ST_EMPTY;
            head_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        head_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        head_load_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (drain_s) begin
                        // Clearing the head keeps out_* at the bubble value when empty.
                        state_nxt_s  = ST_EMPTY;
                        head_clear_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (drain_s) begin
                        state_nxt_s      = ST_ONE;
                        head_load_s      = 1'b1;
                        head_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s  = ST_EMPTY;
                    head_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Skid contents were already kill-filtered on capture.
    assign head_d_ctrl_s = head_from_skid_s ? skid_ctrl_s : in_ctrl;
    assign head_d_data_s = head_from_skid_s ? skid_data_s : in_data;
    assign head_kill_s   = head_from_skid_s ? 1'b0 : in_kill;

    pipe_stage_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_DATA (NOP_DATA)
    ) u_head (
        .clk    (clk),
        .rst    (rst),
        .clear  (head_clear_s),
        .load   (head_load_s),
        .kill   (head_kill_s),
        .d_ctrl (head_d_ctrl_s),
        .d_data (head_d_data_s),
        .q_ctrl (out_ctrl),
        .q_data (out_data)
    );

    pipe_stage_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_DATA (NOP_DATA)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (skid_clear_s),
        .load   (skid_load_s),
        .kill   (in_kill),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl_s),
        .q_data (skid_data_s)
    );

    // Saturating kill counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            kill_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && in_kill && (kill_cnt_r != {CNT_W{1'b1}})) begin
            kill_cnt_r <= kill_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            kill_cnt_r <= kill_cnt_r;
        end
    end

    assign kill_cnt  = kill_cnt_r;
    assign occupancy = state_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int          CTRL_W = 8;
    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 4;
    localparam logic [15:0] NOP    = 16'hDEAD;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_kill;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  kill_cnt;
    logic              clr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] mq[$];
    int          mk = 0;

    pipe_stage_buf #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_DATA(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kill(in_kill), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .flush(flush), .occupancy(occupancy),
        .kill_cnt(kill_cnt), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of at most two words, advanced at each rising edge.
    task automatic tick();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = (rst == 1'b0) && in_valid && !flush && (mq.size() < 2);
        drn = (rst == 1'b0) && out_ready && !flush && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            mk = 0;
        end else begin
            if (clr_cnt) mk = 0;
            else if (acc && in_kill && mk < 15) mk++;
            if (flush) mq.delete();
            else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_kill ? {8'h00, NOP} : {in_ctrl, in_data});
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_kill = 1'b0; in_ctrl = 8'h00; in_data = 16'h0000;
        out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL reset_out_ctrl got %h want 00", out_ctrl); end
        n_cmp++; if (out_data !== NOP) begin n_err++; $display("FAIL reset_out_data got %h want %h", out_data, NOP); end
        n_cmp++; if (kill_cnt !== 4'd0) begin n_err++; $display("FAIL reset_kill_cnt got %0d want 0", kill_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 16'h1234;
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_no_accept got %0d want 0", occupancy); end
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_ctrl = 8'(i + 1); in_data = vals[i];
            tick();
            n_cmp++; if (out_data !== vals[i] || out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out[%0d] got %h/%b want %h/1", i, out_data, out_valid, vals[i]); end
            n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== NOP || out_ctrl !== 8'h00) begin n_err++; $display("FAIL stream_empty got %b/%h/%h want 0/%h/00", out_valid, out_data, out_ctrl, NOP); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h01;
        in_data = 16'h000A; tick();
        in_data = 16'h000B; tick();
        n_cmp++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin n_err++; $display("FAIL bp_full got rdy %b occ %0d want 0/2", in_ready, occupancy); end
        in_data = 16'h000C; tick();
        n_cmp++; if (out_data !== 16'h000A || occupancy !== 2'd2) begin n_err++; $display("FAIL bp_hold got %h occ %0d want 000a/2", out_data, occupancy); end
        out_ready = 1'b1; tick();
        n_cmp++; if (out_data !== 16'h000B || occupancy !== 2'd1) begin n_err++; $display("FAIL bp_rel1 got %h occ %0d want 000b/1", out_data, occupancy); end
        tick();
        n_cmp++; if (out_data !== 16'h000C || occupancy !== 2'd1) begin n_err++; $display("FAIL bp_rel2 got %h occ %0d want 000c/1", out_data, occupancy); end
        in_valid = 1'b0; tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL bp_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_kill();
        out_ready = 1'b0; in_valid = 1'b1; in_kill = 1'b1; in_ctrl = 8'hFF; in_data = 16'h0055;
        tick();
        in_valid = 1'b0; in_kill = 1'b0;
        n_cmp++; if (out_ctrl !== 8'h00 || out_data !== NOP || out_valid !== 1'b1) begin n_err++; $display("FAIL kill_entry got %h/%h/%b want 00/%h/1", out_ctrl, out_data, out_valid, NOP); end
        n_cmp++; if (kill_cnt !== 4'd1) begin n_err++; $display("FAIL kill_cnt got %0d want 1", kill_cnt); end
        out_ready = 1'b1; tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL kill_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A;
        in_data = 16'h0101; tick();
        in_data = 16'h0202; tick();
        flush = 1'b1; out_ready = 1'b1; in_data = 16'h0303;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_comb got %b/%b want 0/0", in_ready, out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got occ %0d vld %b want 0/0", occupancy, out_valid); end
        n_cmp++; if (out_ctrl !== 8'h00 || out_data !== NOP) begin n_err++; $display("FAIL flush_bubble got %h/%h want 00/%h", out_ctrl, out_data, NOP); end
    endtask

    task automatic test_saturate();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_kill = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        n_cmp++; if (kill_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt got %0d want 15", kill_cnt); end
        clr_cnt = 1'b1; tick();
        clr_cnt = 1'b0; in_valid = 1'b0; in_kill = 1'b0;
        n_cmp++; if (kill_cnt !== 4'd0) begin n_err++; $display("FAIL sat_clr got %0d want 0", kill_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic [23:0] exp_head;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_kill   = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            in_ctrl   = 8'($urandom);
            in_data   = 16'($urandom);
            #1;
            exp_head = (mq.size() > 0) ? mq[0] : {8'h00, NOP};
            n_cmp++; if (in_ready !== (!flush && mq.size() < 2)) begin n_err++; $display("FAIL rnd_in_ready c%0d got %b", c, in_ready); end
            n_cmp++; if (out_valid !== (!flush && mq.size() > 0)) begin n_err++; $display("FAIL rnd_out_valid c%0d got %b", c, out_valid); end
            n_cmp++; if ({out_ctrl, out_data} !== exp_head) begin n_err++; $display("FAIL rnd_head c%0d got %h want %h", c, {out_ctrl, out_data}, exp_head); end
            n_cmp++; if (occupancy !== 2'(mq.size())) begin n_err++; $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, mq.size()); end
            n_cmp++; if (kill_cnt !== 4'(mk)) begin n_err++; $display("FAIL rnd_kill_cnt c%0d got %0d want %0d", c, kill_cnt, mk); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h77;
        in_data = 16'h0A0A; tick();
        in_data = 16'h0B0B; tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL ar_fill got %0d want 2", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL ar_immediate got vld %b occ %0d want 0/0", out_valid, occupancy); end
        tick();
        rst = 1'b0; out_ready = 1'b1; in_data = 16'h0C0C;
        tick();
        n_cmp++; if (out_data !== 16'h0C0C || occupancy !== 2'd1) begin n_err++; $display("FAIL ar_resume got %h occ %0d want 0c0c/1", out_data, occupancy); end
        in_valid = 1'b0; tick();
        n_cmp++; if (occupancy !== 2'(mq.size())) begin n_err++; $display("FAIL ar_model got %0d want %0d", occupancy, mq.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_kill();
        test_flush();
        test_saturate();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer: the successor to the fixed per-stage pipeline registers. Carries a generic control bundle and a data bundle between two stages with a valid/ready handshake, a 2-entry skid so backpressure never drops a word, per-entry kill (NOP insertion on capture), and whole-stage flush. Instantiated once per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

## Interface
- CTRL_W, 8: width of control bundle; killed/flushed entries carry all-zero control.
- DATA_W, 64: width of data bundle.
- NOP_DATA, {DATA_W{1'b0}}: data value substituted on kill and presented when empty.
- CNT_W, 16: width of the kill counter.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage can accept this cycle.
- in_kill  in  1  with accept: store entry as bubble (ctrl=0, data=NOP_DATA, valid kept).
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes head this cycle.
- out_ctrl  out  CTRL_W  head control.
- out_data  out  DATA_W  head data.
- flush  in  1  discard all entries this cycle.
- occupancy  out  2  entries held (0, 1, 2).
- kill_cnt  out  CNT_W  saturating count of killed entries accepted.
- clr_cnt  in  1  synchronous clear of kill_cnt.

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = ~flush & (state != TWO); out_valid = ~flush & (state != EMPTY).
- Storage: head register (drives outputs) and skid register.
- State EMPTY: accept -> ONE, word into head.
- State ONE: accept & ~drain -> TWO, word into skid; accept & drain -> ONE, word into head; ~accept & drain -> EMPTY; else hold.
- State TWO: in_ready=0; drain -> ONE, skid moves to head; else hold.
- flush has priority over all: next state EMPTY, head/skid ctrl cleared to 0, data to NOP_DATA; no handshake counts in a flush cycle.
- Kill: captured ctrl forced to 0, data to NOP_DATA; entry still occupies a slot and is drained normally.
- Data order is strictly FIFO; no entry is duplicated or lost under any in/out_ready pattern.
- kill_cnt increments on accept & in_kill, saturates at all-ones, never wraps; clr_cnt zeroes it (clr_cnt wins over a simultaneous increment).
- When empty, out_ctrl = 0, out_data = NOP_DATA.

## Timing
- Reset (async, immediate): state EMPTY, occupancy 0, out_valid 0, out_ctrl 0, out_data NOP_DATA, kill_cnt 0; in_ready reads 1, but no transfer is taken while rst is high.
- Latency: accepted word visible at out_* on the cycle after accept (one register stage).
- Throughput: one word per cycle with out_ready held high; skid fill on one stall cycle, zero bubbles inserted.
- in_ready and out_valid depend combinationally only on registered state and flush; no path from out_ready to in_ready.
- Reset mid-transfer: all entries lost, counter cleared; first accept possible on first edge after rst falls.

## Structure
- Shared package: state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and a bubble-control constant used by all stage instances.
- One sub-module natural: pipe_stage_entry (CTRL_W+DATA_W register with load and kill/clear muxing), instantiated twice for head and skid.
- Top holds the FSM, handshake decode and kill counter.

## Test plan
- Reset then stream 0x11,0x22,0x33 with out_ready=1 -> outputs 0x11,0x22,0x33 on consecutive cycles one cycle after each accept; occupancy stays 1.
- out_ready=0 for 2 cycles while sending 0xA,0xB,0xC -> in_ready drops after 2 accepts, occupancy 2; release -> 0xA,0xB then 0xC in order, none lost.
- Accept 0x55 with in_kill=1, ctrl=0xFF -> out_ctrl 0x00, out_data NOP_DATA, out_valid 1; kill_cnt = 1.
- Fill to occupancy 2, assert flush with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, no word accepted or consumed.
- With CNT_W=4, accept 17 killed entries -> kill_cnt holds 15; clr_cnt with a kill in same cycle -> kill_cnt 0.
- Assert rst asynchronously mid-stall at occupancy 2 -> out_valid 0 and occupancy 0 before next clock edge; traffic resumes normally after release.
